// File: rtl/resize_scale_scheduler.sv
`default_nettype none
// ==========================================================================
// resize_scale_scheduler: pyramid-level sequencer emitting NN-resize coords
// Revision 1.0
// ==========================================================================
module resize_scale_scheduler #(
  parameter int DATA_WIDTH_12                = 12,
  parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 320,
  parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 240,
  parameter int NUM_LEVELS                   = 8,
  parameter int SCALE_Q8                     = 205,
  parameter int INV_SCALE_Q8                 = 320,
  parameter int MIN_WINDOW                   = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [DATA_WIDTH_12-1:0] o_src_x,
  output logic [DATA_WIDTH_12-1:0] o_src_y,
  output logic [DATA_WIDTH_12-1:0] o_resize_x,
  output logic [DATA_WIDTH_12-1:0] o_resize_y,
  output logic [3:0]               o_level,
  output logic [DATA_WIDTH_12-1:0] o_level_w,
  output logic [DATA_WIDTH_12-1:0] o_level_h,
  output logic                     o_level_start,
  output logic                     o_frame_done,
  output logic                     o_busy
);
  localparam int W = DATA_WIDTH_12;
  localparam logic [W-1:0] ORI_W      = W'(FRAME_ORIGINAL_CAMERA_WIDTH);
  localparam logic [W-1:0] ORI_H      = W'(FRAME_ORIGINAL_CAMERA_HEIGHT);
  localparam logic [W-1:0] ORI_W_M1   = ORI_W - W'(1);
  localparam logic [W-1:0] ORI_H_M1   = ORI_H - W'(1);
  localparam logic [W-1:0] MIN_WIN    = W'(MIN_WINDOW);
  localparam logic [3:0]   LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [7:0]   SCALE      = 8'(SCALE_Q8);
  localparam logic [15:0]  INV        = 16'(INV_SCALE_Q8);
  localparam logic [23:0]  RATIO_ONE  = 24'h010000;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEVEL_INIT = 3'd1,
    S_SCAN       = 3'd2,
    S_LEVEL_END  = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t       state;
  logic [W-1:0] w;
  logic [W-1:0] h;
  logic [23:0]  ratio;
  logic [27:0]  acc_x;
  logic [27:0]  acc_y;

  logic [W+7:0] w_prod;
  logic [W+7:0] h_prod;
  logic [W-1:0] w_next;
  logic [W-1:0] h_next;
  logic [39:0]  ratio_prod;
  logic [31:0]  ratio_shr;
  logic [23:0]  ratio_next;
  logic [27:0]  acc_x_inc;
  logic [27:0]  acc_y_inc;
  logic         x_more;
  logic         y_more;
  logic         too_small;
  logic         last_level;

  function automatic logic [W-1:0] sat(input logic [11:0] v, input logic [W-1:0] lim);
    sat = (W'(v) > lim) ? lim : W'(v);
  endfunction

  assign w_prod     = {8'd0, w} * {{W{1'b0}}, SCALE};
  assign h_prod     = {8'd0, h} * {{W{1'b0}}, SCALE};
  assign w_next     = W'(w_prod >> 8);
  assign h_next     = W'(h_prod >> 8);
  assign ratio_prod = {16'd0, ratio} * {24'd0, INV};
  assign ratio_shr  = 32'(ratio_prod >> 8);
  // Ratio saturates instead of wrapping so deep levels never alias to small steps
  assign ratio_next = (|ratio_shr[31:24]) ? 24'hFFFFFF : ratio_shr[23:0];
  assign acc_x_inc  = acc_x + {4'd0, ratio};
  assign acc_y_inc  = acc_y + {4'd0, ratio};
  assign x_more     = o_resize_x < (w - W'(1));
  assign y_more     = o_resize_y < (h - W'(1));
  assign too_small  = (w < MIN_WIN) || (h < MIN_WIN);
  assign last_level = (o_level == LAST_LEVEL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      w             <= ORI_W;
      h             <= ORI_H;
      ratio         <= RATIO_ONE;
      acc_x         <= '0;
      acc_y         <= '0;
      o_valid       <= 1'b0;
      o_src_x       <= '0;
      o_src_y       <= '0;
      o_resize_x    <= '0;
      o_resize_y    <= '0;
      o_level       <= '0;
      o_level_w     <= '0;
      o_level_h     <= '0;
      o_level_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_level_start <= 1'b0;
      o_frame_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            w         <= ORI_W;
            h         <= ORI_H;
            ratio     <= RATIO_ONE;
            o_level   <= '0;
            o_level_w <= ORI_W;
            o_level_h <= ORI_H;
            o_busy    <= 1'b1;
            state     <= S_LEVEL_INIT;
          end
        end
        S_LEVEL_INIT: begin
          if (too_small) begin
            o_frame_done <= 1'b1;
            state        <= S_DONE;
          end else begin
            acc_x         <= '0;
            acc_y         <= '0;
            o_resize_x    <= '0;
            o_resize_y    <= '0;
            o_src_x       <= '0;
            o_src_y       <= '0;
            o_valid       <= 1'b1;
            o_level_start <= 1'b1;
            state         <= S_SCAN;
          end
        end
        S_SCAN: begin
          // o_valid is always high here, so i_ready alone marks a handshake
          if (i_ready) begin
            if (x_more) begin
              o_resize_x <= o_resize_x + W'(1);
              acc_x      <= acc_x_inc;
              o_src_x    <= sat(acc_x_inc[27:16], ORI_W_M1);
            end else begin
              o_resize_x <= '0;
              acc_x      <= '0;
              o_src_x    <= '0;
              if (y_more) begin
                o_resize_y <= o_resize_y + W'(1);
                acc_y      <= acc_y_inc;
                o_src_y    <= sat(acc_y_inc[27:16], ORI_H_M1);
              end else begin
                o_valid <= 1'b0;
                state   <= S_LEVEL_END;
              end
            end
          end
        end
        S_LEVEL_END: begin
          if (last_level) begin
            o_frame_done <= 1'b1;
            state        <= S_DONE;
          end else begin
            w         <= w_next;
            h         <= h_next;
            ratio     <= ratio_next;
            o_level   <= o_level + 4'd1;
            o_level_w <= w_next;
            o_level_h <= h_next;
            state     <= S_LEVEL_INIT;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
